chunk_adder: RTL and testbench
==============================

Name: chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, and ripples the carry between cycles in a register.
- Start/busy/done handshake; the result is held until the next operation.
- Sits beside the datapath as the wide arithmetic unit where a full-width single-cycle carry chain is too slow or too large.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 8, bits added per clock. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- sub  input  1  0 = add, 1 = subtract; sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in (add) / borrow-in (sub), sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  carry-out (add) / not-borrow (sub)
- ovf  output  1  signed overflow (only with CHUNK_ADDER_OVF_EN)

Behaviour:
- Reset values: state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; slice index 0; carry register 0.
- rst overrides everything, including mid-RUN. The operation in flight is discarded and no done is produced.
- States:
  - IDLE.
  - RUN, with slice index 0..N-1.
  - DONE.
- IDLE/DONE + start=1 at edge k:
  - Latch A=a.
  - Latch B=b when sub=0, B=~b when sub=1.
  - Latch carry=cin when sub=0, carry=~cin when sub=1.
  - Index 0, state RUN.
  - sum and cout hold their old values until the first slice write.
- IDLE/DONE + start=0: DONE goes to IDLE; IDLE stays in IDLE.
- RUN, each edge:
  - {c, s} = A[i*CHUNK +: CHUNK] + B[i*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - Write s into sum slice i; carry <= c; i <= i+1.
- At the edge processing slice N-1:
  - cout <= c; state DONE.
  - Index wraps to 0.
- Timing:
  - busy=1 for exactly N cycles, from the cycle after edge k.
  - done=1 for exactly one cycle, after edge k+N.
  - Start-to-done latency is N edges.
  - Minimum issue interval is N+1 cycles, because start is accepted in the DONE cycle for back-to-back operation.
- Arithmetic results:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: sum = a - b - cin (mod 2^WIDTH); cout=1 means no borrow.
- start, sub, a, b and cin are ignored while in RUN; operands are not re-sampled.
- sum is only guaranteed final when done=1 or afterwards. Intermediate slices are visible during RUN.
- N=1 (CHUNK=WIDTH) is legal: one RUN cycle, then DONE.

Optional Feature:
- CHUNK_ADDER_OVF_EN defined:
  - Port ovf exists.
  - At the final slice edge, ovf <= carry into the MSB XOR carry out of the MSB, i.e. two's-complement overflow of the WIDTH-bit result.
  - ovf holds with sum; reset value 0.
- CHUNK_ADDER_OVF_EN not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Default params. a=32'hFFFFFFFF, b=1, cin=0, sub=0, start pulse at edge k:
  - busy high for 4 cycles.
  - done high only in the cycle after edge k+4.
  - sum=0, cout=1.
- sub=1, a=5, b=7, cin=0 -> sum=32'hFFFFFFFE, cout=0, ovf=0. Then sub=1, a=7, b=5, cin=1 -> sum=1, cout=1.
- OVF_EN defined. a=32'h7FFFFFFF, b=1, add -> sum=32'h80000000, cout=0, ovf=1. Then a=32'h80000000, b=32'h80000000 -> sum=0, cout=1, ovf=1.
- Operation A in RUN:
  - Pulse start with different operands -> ignored; A's result is unchanged.
  - Assert rst at the second RUN cycle -> next cycle all outputs 0, state IDLE, no done pulse.
- WIDTH=12, CHUNK=4. a=12'hABC, b=12'h544, cin=1 -> sum=12'h001, cout=1 after 3 RUN cycles. WIDTH=8, CHUNK=8: a=8'h80, b=8'h80 -> sum=0, cout=1 with 1 RUN cycle.
- start held high continuously with fixed operands:
  - New operation accepted in every DONE cycle.
  - done pulses every N+1 cycles.
  - Same result each time.

Source files
------------

// File: rtl/chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock.
// Optional signed-overflow output when CHUNK_ADDER_OVF_EN is defined.
module chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef CHUNK_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef CHUNK_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
  logic              cmsb;
`endif

  logic [CHUNK-1:0]  a_s;
  logic [CHUNK-1:0]  b_s;
  logic [CHUNK:0]    cs;
  logic              last;

  // Current slice add, carry-out in the top bit
  always_comb begin
    a_s  = a_q[idx_q*CHUNK +: CHUNK];
    b_s  = b_q[idx_q*CHUNK +: CHUNK];
    cs   = {1'b0, a_s} + {1'b0, b_s} + (CHUNK+1)'(carry_q);
    last = (idx_q == IW'(N-1));
`ifdef CHUNK_ADDER_OVF_EN
    cmsb = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ cs[CHUNK-1];
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CHUNK_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = cs[CHUNK-1:0];
        carry_d = cs[CHUNK];
        if (last) begin
          cout_d  = cs[CHUNK];
`ifdef CHUNK_ADDER_OVF_EN
          ovf_d   = cmsb ^ cs[CHUNK];
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNK_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CHUNK_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs decoded from state and held registers
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
`ifdef CHUNK_ADDER_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_chunk_adder.sv
// Directed bench for chunk_adder: 32/8, 12/4 and 8/8 instances.
// Vector table on the 32/8 instance plus handshake corner sequences.
module tb_chunk_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        start0, sub0, cin0, busy0, done0, cout0;
  logic [31:0] a0, b0, sum0;
  logic        start1, sub1, cin1, busy1, done1, cout1;
  logic [11:0] a1, b1, sum1;
  logic        start2, sub2, cin2, busy2, done2, cout2;
  logic [7:0]  a2, b2, sum2;
`ifdef CHUNK_ADDER_OVF_EN
  logic        ovf0, ovf1, ovf2;
`endif

  chunk_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub0),
    .a(a0), .b(b0), .cin(cin0), .busy(busy0), .done(done0),
    .sum(sum0),
`ifdef CHUNK_ADDER_OVF_EN
    .ovf(ovf0),
`endif
    .cout(cout0)
  );

  chunk_adder #(.WIDTH(12), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1),
    .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
    .sum(sum1),
`ifdef CHUNK_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .cout(cout1)
  );

  chunk_adder #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2),
    .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2),
    .sum(sum2),
`ifdef CHUNK_ADDER_OVF_EN
    .ovf(ovf2),
`endif
    .cout(cout2)
  );

  typedef struct {
    string       name;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vec[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op on u0, count busy cycles until done (bounded)
  task automatic run0(input logic s, input logic [31:0] aa,
                      input logic [31:0] bb, input logic ci,
                      output int nb, output bit got);
    @(negedge clk);
    start0 = 1'b1; sub0 = s; a0 = aa; b0 = bb; cin0 = ci;
    @(negedge clk);
    start0 = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done0) got = 1;
      else begin
        if (busy0) nb++;
        @(negedge clk);
      end
    end
  endtask

  int nb;
  bit got;
  int cnt;

  initial begin
    vec[0] = '{"add_wrap", 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0,
               32'h0, 1'b1, 1'b0};
    vec[1] = '{"sub_5_7", 1'b1, 32'h5, 32'h7, 1'b0,
               32'hFFFFFFFE, 1'b0, 1'b0};
    vec[2] = '{"sub_7_5_c", 1'b1, 32'h7, 32'h5, 1'b1,
               32'h1, 1'b1, 1'b0};
    vec[3] = '{"add_ovf_pos", 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0,
               32'h80000000, 1'b0, 1'b1};
    vec[4] = '{"add_ovf_neg", 1'b0, 32'h80000000, 32'h80000000,
               1'b0, 32'h0, 1'b1, 1'b1};
    vec[5] = '{"add_mix", 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1,
               32'hACF13569, 1'b0, 1'b0};
    vec[6] = '{"sub_0_0_c", 1'b1, 32'h0, 32'h0, 1'b1,
               32'hFFFFFFFF, 1'b0, 1'b0};
    vec[7] = '{"sub_ovf", 1'b1, 32'h80000000, 32'h1, 1'b0,
               32'h7FFFFFFF, 1'b1, 1'b1};

    rst = 1'b1;
    {start0, sub0, cin0} = '0; a0 = '0; b0 = '0;
    {start1, sub1, cin1} = '0; a1 = '0; b1 = '0;
    {start2, sub2, cin2} = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_sum", 64'(sum0), 64'd0);
    chk("rst_cout", 64'(cout0), 64'd0);
`ifdef CHUNK_ADDER_OVF_EN
    chk("rst_ovf", 64'(ovf0), 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run0(vec[i].sub, vec[i].a, vec[i].b, vec[i].cin, nb, got);
      chk({vec[i].name, "_done"}, 64'(got), 64'd1);
      chk({vec[i].name, "_busy"}, 64'(nb), 64'd4);
      chk({vec[i].name, "_sum"}, 64'(sum0), 64'(vec[i].sum));
      chk({vec[i].name, "_cout"}, 64'(cout0), 64'(vec[i].cout));
`ifdef CHUNK_ADDER_OVF_EN
      chk({vec[i].name, "_ovf"}, 64'(ovf0), 64'(vec[i].ovf));
`endif
      @(negedge clk);
      chk({vec[i].name, "_pulse"}, 64'(done0), 64'd0);
    end

    // start during RUN must be ignored
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 32'd1; b0 = 32'd2; cin0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b1; a0 = '1; b0 = '1; cin0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done0) got = 1;
      else @(negedge clk);
    end
    chk("ign_done", 64'(got), 64'd1);
    chk("ign_sum", 64'(sum0), 64'd3);
    chk("ign_cout", 64'(cout0), 64'd0);

    // reset in second RUN cycle
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 32'h11111111;
    b0 = 32'h22222222; cin0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_done", 64'(done0), 64'd0);
    chk("mid_rst_sum", 64'(sum0), 64'd0);
    chk("mid_rst_cout", 64'(cout0), 64'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0 || busy0) cnt++;
    end
    chk("mid_rst_quiet", 64'(cnt), 64'd0);

    // 12/4: three RUN cycles
    @(negedge clk);
    start1 = 1'b1; sub1 = 1'b0; a1 = 12'hABC; b1 = 12'h544; cin1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done1) got = 1;
      else begin
        if (busy1) nb++;
        @(negedge clk);
      end
    end
    chk("w12_done", 64'(got), 64'd1);
    chk("w12_busy", 64'(nb), 64'd3);
    chk("w12_sum", 64'(sum1), 64'h001);
    chk("w12_cout", 64'(cout1), 64'd1);

    // 8/8: single RUN cycle
    @(negedge clk);
    start2 = 1'b1; sub2 = 1'b0; a2 = 8'h80; b2 = 8'h80; cin2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done2) got = 1;
      else begin
        if (busy2) nb++;
        @(negedge clk);
      end
    end
    chk("w8_done", 64'(got), 64'd1);
    chk("w8_busy", 64'(nb), 64'd1);
    chk("w8_sum", 64'(sum2), 64'h00);
    chk("w8_cout", 64'(cout2), 64'd1);

    // start held high: done every N+1 cycles
    @(negedge clk);
    start0 = 1'b1; sub0 = 1'b0; a0 = 32'd1; b0 = 32'd1; cin0 = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done0) got = 1;
    end
    chk("b2b_first", 64'(got), 64'd1);
    chk("b2b_sum0", 64'(sum0), 64'd3);
    for (int r = 0; r < 3; r++) begin
      cnt = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        cnt++;
        if (done0) got = 1;
      end
      chk("b2b_period", 64'(cnt), 64'd5);
      chk("b2b_sum", 64'(sum0), 64'd3);
    end
    start0 = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
